// File: rtl/keypad_clock_div.sv
// Keypad scan clock divider with combinational priority encoder and a per-scan-period key latch.
// Optional single-cycle tick on each clk_out rise, enabled by defining KEYPAD_CLOCK_DIV_TICK_EN.
module keypad_clock_div #(
  parameter int HALF_PERIOD = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] keys,
  output logic        clk_out,
  output logic [3:0]  code,
  output logic        valid,
  output logic [3:0]  code_q,
  output logic        valid_q,
  output logic        tick
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clk_out_q;
  logic          wrap;
  logic          rise;

  // Ascending scan: the last set bit seen wins, so bit 11 has top priority.
  always_comb begin
    code = 4'hF;
    for (int i = 0; i < 12; i++) begin
      if (keys[i]) code = 4'(i);
    end
  end

  assign valid = |keys;

  assign wrap  = (cnt_q == CNT_TOP);
  assign rise  = wrap & ~clk_out_q;
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      code_q    <= 4'hF;
      valid_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (wrap) clk_out_q <= ~clk_out_q;
      if (rise) begin
        code_q  <= code;
        valid_q <= valid;
      end
    end
  end

  assign clk_out = clk_out_q;

`ifdef KEYPAD_CLOCK_DIV_TICK_EN
  logic tick_q;

  // Registered on the same edge that raises clk_out, so both go high together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_q <= 1'b0;
    else       tick_q <= rise;
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_clock_div.sv
// Directed bench for keypad_clock_div at HALF_PERIOD=4 with a scoreboard queue of expected codes.
module tb_keypad_clock_div;

  logic        clk;
  logic        reset;
  logic [11:0] keys;
  logic        clk_out;
  logic [3:0]  code;
  logic        valid;
  logic [3:0]  code_q;
  logic        valid_q;
  logic        tick;

  typedef struct {
    logic [3:0] code;
    logic       valid;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;
  int   edge_n;

  keypad_clock_div #(.HALF_PERIOD(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .keys    (keys),
    .clk_out (clk_out),
    .code    (code),
    .valid   (valid),
    .code_q  (code_q),
    .valid_q (valid_q),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference encoder: descending search, first set bit is the answer.
  function automatic exp_t model(input logic [11:0] k);
    exp_t e;
    e.code  = 4'hF;
    e.valid = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      if (k[i]) begin
        e.code  = 4'(i);
        e.valid = 1'b1;
        break;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic tick_exp(input int e);
`ifdef KEYPAD_CLOCK_DIV_TICK_EN
    return (e % 8) == 4;
`else
    return 1'b0;
`endif
  endfunction

  // One clk edge, then check the divider phase and tick against the edge count since reset release.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    chk($sformatf("clk_out@e%0d", edge_n), 32'(clk_out), 32'((edge_n / 4) % 2));
    chk($sformatf("tick@e%0d", edge_n), 32'(tick), 32'(tick_exp(edge_n)));
  endtask

  task automatic drive_comb(input logic [11:0] k);
    exp_t e;
    keys = k;
    sb.push_back(model(k));
    #1;
    e = sb.pop_front();
    chk($sformatf("code[%03h]", k), 32'(code), 32'(e.code));
    chk($sformatf("valid[%03h]", k), 32'(valid), 32'(e.valid));
  endtask

  task automatic pop_reg(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".code_q"}, 32'(code_q), 32'(e.code));
      chk({tag, ".valid_q"}, 32'(valid_q), 32'(e.valid));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    edge_n = 0;
    reset  = 1'b1;
    keys   = 12'h000;

    #3;
    chk("rst.clk_out", 32'(clk_out), 32'd0);
    chk("rst.code_q", 32'(code_q), 32'hF);
    chk("rst.valid_q", 32'(valid_q), 32'd0);
    chk("rst.tick", 32'(tick), 32'd0);
    chk("rst.code", 32'(code), 32'hF);

    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    repeat (16) step();
    chk("idle.code", 32'(code), 32'hF);
    chk("idle.valid", 32'(valid), 32'd0);
    chk("idle.code_q", 32'(code_q), 32'hF);

    drive_comb(12'h004);
    drive_comb(12'h804);
    drive_comb(12'h001);
    drive_comb(12'h400);
    drive_comb(12'h000);

    // Latch path: keys cleared before the rise at edge 20.
    sb.push_back(model(12'h000));
    repeat (4) step();
    pop_reg("rise20");

    step();
    keys = 12'h020;
    sb.push_back(model(keys));
    repeat (6) begin
      step();
      chk($sformatf("hold@e%0d", edge_n), 32'(code_q), 32'hF);
    end
    step();
    pop_reg("rise28");

    // Asynchronous reset mid-count, between clk edges.
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst.clk_out", 32'(clk_out), 32'd0);
    chk("arst.code_q", 32'(code_q), 32'hF);
    chk("arst.valid_q", 32'(valid_q), 32'd0);
    chk("arst.tick", 32'(tick), 32'd0);
    chk("arst.code", 32'(code), 32'h5);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    sb.push_back(model(keys));
    repeat (3) begin
      step();
      chk($sformatf("post@e%0d", edge_n), 32'(code_q), 32'hF);
    end
    step();
    pop_reg("rerise4");
    repeat (4) step();

    for (int k = 0; k < 4096; k++) drive_comb(12'(k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_clock_div.md
KEYPAD_CLOCK_DIV -- requirements
Module: keypad_clock_div

Interface
REQ-001 Parameter: HALF_PERIOD, default 500000, clk cycles per clk_out half-period (500000 gives 100 Hz from a 100 MHz clk); legal range 1 .. 2^31-1.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 keys  input  12  active-high key-detect vector: bit 0..9 = digits 0..9, bit 10 = '*', bit 11 = '#'.
REQ-005 clk_out  output  1  divided keypad scan clock, 50% duty.
REQ-006 code  output  4  combinational priority-encoded key code.
REQ-007 valid  output  1  combinational, high when any keys bit is set.
REQ-008 code_q  output  4  code, registered once per clk_out period.
REQ-009 valid_q  output  1  valid, registered alongside code_q.
REQ-010 tick  output  1  single-cycle strobe marking each clk_out rise (see Configuration).

Function
REQ-011 The internal counter shall be wide enough for HALF_PERIOD-1; it increments each clk and, at HALF_PERIOD-1, wraps to 0 while clk_out toggles.
REQ-012 clk_out period shall be exactly 2*HALF_PERIOD clk cycles; the first 0->1 transition occurs on the HALF_PERIOD-th rising clk edge after reset deasserts.
REQ-013 HALF_PERIOD=1 shall toggle clk_out on every clk edge (period 2 cycles).
REQ-014 code shall equal the index of the highest set keys bit (bit 11 has top priority); keys=0 shall give code=4'hF.
REQ-015 valid shall equal OR of keys; code=4'h0 with valid=1 means key '0', distinct from the no-key case.
REQ-016 code/valid shall be purely combinational, with no clock dependency.
REQ-017 On the clk edge where clk_out goes 0->1, code_q<=code and valid_q<=valid; at all other edges they hold.
REQ-018 Key changes between clk_out rises shall not affect code_q/valid_q until the next rise.
REQ-019 Values 4'hC..4'hE shall never appear on code or code_q.

Reset
REQ-020 reset asserted shall immediately, without waiting for clk, force counter=0, clk_out=0, code_q=4'hF, valid_q=0, tick=0.
REQ-021 Reset asserted mid-count shall discard the partial count; after release, timing restarts per REQ-012.
REQ-022 code/valid shall follow keys even during reset.

Configuration
REQ-023 Macro KEYPAD_CLOCK_DIV_TICK_EN: when defined, tick shall be high for exactly one clk cycle, registered on the same edge on which clk_out rises.
REQ-024 Without KEYPAD_CLOCK_DIV_TICK_EN, the tick port shall remain present and be tied constant 0; all other behaviour shall be identical.

Verification (HALF_PERIOD=4)
REQ-025 Release reset, keys=0 -> clk_out rises at edge 4, falls at edge 8, rises at edge 12; code=F, valid=0, code_q=F.
REQ-026 keys=12'h004 -> code=2, valid=1; keys=12'h804 -> code=B; keys=12'h001 -> code=0, valid=1; keys=12'h400 -> code=A.
REQ-027 keys=12'h020 set 1 cycle after a clk_out rise -> code_q stays F until the next rise (7 cycles later), then code_q=5, valid_q=1.
REQ-028 Assert reset 2 cycles after a clk_out rise, between clk edges -> clk_out=0 and code_q=F at once; after release, next rise at edge 4.
REQ-029 With KEYPAD_CLOCK_DIV_TICK_EN defined -> tick is high one cycle every 8 cycles, coincident with the clk_out rise; without the macro -> tick constantly 0.
REQ-030 Exhaustive sweep of all 4096 keys values -> code matches highest-set-bit index (F for zero) and valid matches OR-reduce.
